vend_dispense_ctrl: RTL and testbench

Back-end sequencer for the vending machine: accepts a completed purchase or cancel from the front-end selection/payment FSM, checks and decrements per-item stock, drives the item motor for a fixed time, and pays out change or a refund as 20/10/5 coins over a req/ack handshake with the coin hopper. It owns the stock counters and is the only block that touches the motor and hopper.

---
 rtl/vend_pkg.sv | 40 ++++
 rtl/vend_stock_table.sv | 40 ++++
 rtl/vend_dispense_ctrl.sv | 178 +++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine dispense back end.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DISPENSE,
        ST_CHANGE_SEL,
        ST_COIN_WAIT,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_5    = 2'd1,
        COIN_10   = 2'd2,
        COIN_20   = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        STAT_OK         = 2'd0,
        STAT_REFUND     = 2'd1,
        STAT_NO_STOCK   = 2'd2,
        STAT_COIN_FAULT = 2'd3
    } status_t;

    localparam int COIN_VAL_5  = 5;
    localparam int COIN_VAL_10 = 10;
    localparam int COIN_VAL_20 = 20;

    function automatic int coin_value(input coin_t c);
        case (c)
            COIN_5:  return COIN_VAL_5;
            COIN_10: return COIN_VAL_10;
            COIN_20: return COIN_VAL_20;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_table.sv
// Per-slot stock counters: decrement on sale, reload on restock (restock wins),
// plus a check read port for the FSM and a combinational query port.
module vend_stock_table #(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 3,
    parameter int INIT_STOCK = 7
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         dec_en,
    input  logic [$clog2(NUM_ITEMS)-1:0] dec_item,
    input  logic                         restock_en,
    input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
    input  logic [$clog2(NUM_ITEMS)-1:0] chk_item,
    output logic [STOCK_W-1:0]           chk_stock,
    input  logic [$clog2(NUM_ITEMS)-1:0] q_item,
    output logic [STOCK_W-1:0]           q_stock
);
    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);

    logic [STOCK_W-1:0] stock [NUM_ITEMS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= INIT_VAL;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock_en && restock_item == IDX_W'(i))
                    stock[i] <= INIT_VAL;
                else if (dec_en && dec_item == IDX_W'(i))
                    stock[i] <= stock[i] - 1'b1;
            end
        end
    end

    assign chk_stock = stock[chk_item];
    assign q_stock   = stock[q_item];

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: stock check, timed motor drive, greedy 20/10/5 change payout.
// state      | meaning
// IDLE       | waiting for a purchase or cancel
// CHECK      | price/stock test, decrement stock on sale
// DISPENSE   | motor on for MOTOR_CYCLES
// CHANGE_SEL | pick largest coin not exceeding remain, or finish
// COIN_WAIT  | coin_req held until ack or timeout
// FINISH     | done pulse with status and shortfall
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS    = 4,
    parameter int MONEY_W      = 6,
    parameter int STOCK_W      = 3,
    parameter int INIT_STOCK   = 7,
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         txn_valid,
    output logic                         txn_ready,
    input  logic [$clog2(NUM_ITEMS)-1:0] txn_item,
    input  logic [MONEY_W-1:0]           txn_paid,
    input  logic [MONEY_W-1:0]           txn_price,
    input  logic                         txn_cancel,
    input  logic                         restock_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
    input  logic [$clog2(NUM_ITEMS)-1:0] stock_q_item,
    output logic [STOCK_W-1:0]           stock_q,
    output logic [NUM_ITEMS-1:0]         motor_en,
    output logic                         coin_req,
    output logic [1:0]                   coin_type,
    input  logic                         coin_ack,
    output logic                         done,
    output logic [1:0]                   status,
    output logic [MONEY_W-1:0]           change_short
);
    localparam int IDX_W   = $clog2(NUM_ITEMS);
    localparam int CNT_MAX = (MOTOR_CYCLES > ACK_TIMEOUT) ? MOTOR_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [MONEY_W-1:0]   V5        = MONEY_W'(COIN_VAL_5);
    localparam logic [MONEY_W-1:0]   V10       = MONEY_W'(COIN_VAL_10);
    localparam logic [MONEY_W-1:0]   V20       = MONEY_W'(COIN_VAL_20);
    localparam logic [NUM_ITEMS-1:0] MOTOR_ONE = NUM_ITEMS'(1);

    state_t             state;
    logic [IDX_W-1:0]   item_q;
    logic [MONEY_W-1:0] paid_q;
    logic [MONEY_W-1:0] price_q;
    logic               cancel_q;
    logic [MONEY_W-1:0] remain;
    logic [CNT_W-1:0]   cnt;
    coin_t              coin_q;
    status_t            status_q;
    logic [STOCK_W-1:0] chk_stock;
    logic               dec_en;

    assign dec_en = (state == ST_CHECK) && !cancel_q && (paid_q >= price_q) && (chk_stock != '0);

    vend_stock_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK)
    ) u_stock (
        .clk         (clk),
        .reset_n     (reset_n),
        .dec_en      (dec_en),
        .dec_item    (item_q),
        .restock_en  (restock_valid),
        .restock_item(restock_item),
        .chk_item    (item_q),
        .chk_stock   (chk_stock),
        .q_item      (stock_q_item),
        .q_stock     (stock_q)
    );

    // Outputs are registered alongside the state so they change only with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            item_q       <= '0;
            paid_q       <= '0;
            price_q      <= '0;
            cancel_q     <= 1'b0;
            remain       <= '0;
            cnt          <= '0;
            coin_q       <= COIN_NONE;
            status_q     <= STAT_OK;
            motor_en     <= '0;
            coin_req     <= 1'b0;
            done         <= 1'b0;
            change_short <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (txn_valid) begin
                        item_q   <= txn_item;
                        paid_q   <= txn_paid;
                        price_q  <= txn_price;
                        cancel_q <= txn_cancel;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cancel_q || paid_q < price_q) begin
                        remain   <= paid_q;
                        status_q <= STAT_REFUND;
                        state    <= ST_CHANGE_SEL;
                    end else if (chk_stock == '0) begin
                        remain   <= paid_q;
                        status_q <= STAT_NO_STOCK;
                        state    <= ST_CHANGE_SEL;
                    end else begin
                        remain   <= paid_q - price_q;
                        status_q <= STAT_OK;
                        motor_en <= MOTOR_ONE << item_q;
                        cnt      <= CNT_W'(MOTOR_CYCLES - 1);
                        state    <= ST_DISPENSE;
                    end
                end
                ST_DISPENSE: begin
                    if (cnt == '0) begin
                        motor_en <= '0;
                        state    <= ST_CHANGE_SEL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CHANGE_SEL: begin
                    cnt <= CNT_W'(ACK_TIMEOUT - 1);
                    if (remain >= V20) begin
                        coin_q   <= COIN_20;
                        coin_req <= 1'b1;
                        state    <= ST_COIN_WAIT;
                    end else if (remain >= V10) begin
                        coin_q   <= COIN_10;
                        coin_req <= 1'b1;
                        state    <= ST_COIN_WAIT;
                    end else if (remain >= V5) begin
                        coin_q   <= COIN_5;
                        coin_req <= 1'b1;
                        state    <= ST_COIN_WAIT;
                    end else begin
                        done         <= 1'b1;
                        change_short <= remain;
                        state        <= ST_FINISH;
                    end
                end
                ST_COIN_WAIT: begin
                    if (coin_ack) begin
                        remain   <= remain - MONEY_W'(coin_value(coin_q));
                        coin_q   <= COIN_NONE;
                        coin_req <= 1'b0;
                        state    <= ST_CHANGE_SEL;
                    end else if (cnt == '0) begin
                        status_q     <= STAT_COIN_FAULT;
                        coin_q       <= COIN_NONE;
                        coin_req     <= 1'b0;
                        done         <= 1'b1;
                        change_short <= remain;
                        state        <= ST_FINISH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign txn_ready = (state == ST_IDLE);
    assign coin_type = coin_q;
    assign status    = status_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: a table of transactions with hand-computed
// results, then reset-abort sequence.
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       txn_valid = 1'b0;
    logic       txn_ready;
    logic [1:0] txn_item = '0;
    logic [5:0] txn_paid = '0;
    logic [5:0] txn_price = '0;
    logic       txn_cancel = 1'b0;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_item = '0;
    logic [1:0] stock_q_item = '0;
    logic [2:0] stock_q;
    logic [3:0] motor_en;
    logic       coin_req;
    logic [1:0] coin_type;
    logic       coin_ack = 1'b0;
    logic       done;
    logic [1:0] status;
    logic [5:0] change_short;

    int checks = 0;
    int errors = 0;

    vend_dispense_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .txn_valid    (txn_valid),
        .txn_ready    (txn_ready),
        .txn_item     (txn_item),
        .txn_paid     (txn_paid),
        .txn_price    (txn_price),
        .txn_cancel   (txn_cancel),
        .restock_valid(restock_valid),
        .restock_item (restock_item),
        .stock_q_item (stock_q_item),
        .stock_q      (stock_q),
        .motor_en     (motor_en),
        .coin_req     (coin_req),
        .coin_type    (coin_type),
        .coin_ack     (coin_ack),
        .done         (done),
        .status       (status),
        .change_short (change_short)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] item;
        logic [5:0] paid;
        logic [5:0] price;
        bit         cancel;
        bit         ack;
        bit         restock;
        int         motor_cyc;
        logic [3:0] motor_val;
        int         ncoin;
        logic [5:0] coins;     // coin i at [2i+:2]
        int         req_cyc;
        logic [1:0] status;
        logic [5:0] short_amt;
        int         done_cyc;
        logic [2:0] stock;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [1:0] item, input logic [5:0] paid, input logic [5:0] price,
                                input bit cancel, input bit ack, input bit restock,
                                input int mcyc, input logic [3:0] mval, input int ncoin,
                                input logic [5:0] coins, input int reqc, input logic [1:0] st,
                                input logic [5:0] sh, input int dcyc, input logic [2:0] stock);
        vec_t v;
        v.item = item; v.paid = paid; v.price = price; v.cancel = cancel; v.ack = ack;
        v.restock = restock; v.motor_cyc = mcyc; v.motor_val = mval; v.ncoin = ncoin;
        v.coins = coins; v.req_cyc = reqc; v.status = st; v.short_amt = sh;
        v.done_cyc = dcyc; v.stock = stock;
        return v;
    endfunction

    task automatic run_vec(input vec_t t, input int idx);
        int         cyc = 1;
        int         mcyc = 0;
        int         ncoin = 0;
        int         reqc = 0;
        logic [3:0] mval = '0;
        logic [5:0] coins = '0;
        logic       prev_req = 1'b0;
        bit         got_done = 0;
        logic [1:0] st = '0;
        logic [5:0] sh = '0;
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), txn_ready, 1);
        txn_valid = 1'b1; txn_item = t.item; txn_paid = t.paid;
        txn_price = t.price; txn_cancel = t.cancel;
        @(negedge clk);
        txn_valid = 1'b0;
        chk($sformatf("v%0d_ready_busy", idx), txn_ready, 0);
        while (!got_done && cyc < 100) begin
            if (cyc == 1 && t.restock) begin
                restock_valid = 1'b1; restock_item = t.item;
            end else begin
                restock_valid = 1'b0;
            end
            if (motor_en != '0) begin mcyc++; mval = motor_en; end
            if (coin_req) begin
                reqc++;
                if (!prev_req) begin
                    if (ncoin < 3) coins[2*ncoin +: 2] = coin_type;
                    ncoin++;
                end
                coin_ack = t.ack;
            end else begin
                coin_ack = 1'b0;
            end
            prev_req = coin_req;
            if (done) begin
                got_done = 1; st = status; sh = change_short;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        coin_ack = 1'b0;
        restock_valid = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), got_done, 1);
        chk($sformatf("v%0d_done_cyc", idx), cyc, t.done_cyc);
        chk($sformatf("v%0d_status", idx), st, t.status);
        chk($sformatf("v%0d_change_short", idx), sh, t.short_amt);
        chk($sformatf("v%0d_motor_cycles", idx), mcyc, t.motor_cyc);
        chk($sformatf("v%0d_motor_val", idx), mval, t.motor_val);
        chk($sformatf("v%0d_ncoin", idx), ncoin, t.ncoin);
        chk($sformatf("v%0d_coins", idx), coins, t.coins);
        chk($sformatf("v%0d_req_cycles", idx), reqc, t.req_cyc);
        stock_q_item = t.item;
        #1;
        chk($sformatf("v%0d_stock", idx), stock_q, t.stock);
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", idx), txn_ready, 1);
        chk($sformatf("v%0d_done_pulse", idx), done, 0);
    endtask

    initial begin
        // item paid price cancel ack restock | motor val ncoin coins reqc status short done stock
        vecs[0]  = mk(2'd1, 6'd20, 6'd15, 0, 1, 0, 8, 4'b0010, 1, 6'b00_00_01, 1, 2'd0, 6'd0,  13, 3'd6);
        vecs[1]  = mk(2'd0, 6'd45, 6'd7,  0, 1, 0, 8, 4'b0001, 3, 6'b01_10_11, 3, 2'd0, 6'd3,  17, 3'd6);
        vecs[2]  = mk(2'd2, 6'd30, 6'd10, 1, 1, 0, 0, 4'b0000, 2, 6'b00_10_11, 2, 2'd1, 6'd0,  7,  3'd7);
        vecs[3]  = mk(2'd0, 6'd10, 6'd10, 0, 1, 0, 8, 4'b0001, 0, 6'b00_00_00, 0, 2'd0, 6'd0,  11, 3'd5);
        vecs[4]  = mk(2'd2, 6'd5,  6'd10, 0, 1, 0, 0, 4'b0000, 1, 6'b00_00_01, 1, 2'd1, 6'd0,  5,  3'd7);
        vecs[5]  = mk(2'd2, 6'd4,  6'd0,  0, 1, 0, 8, 4'b0100, 0, 6'b00_00_00, 0, 2'd0, 6'd4,  11, 3'd6);
        vecs[6]  = mk(2'd1, 6'd5,  6'd5,  0, 1, 1, 8, 4'b0010, 0, 6'b00_00_00, 0, 2'd0, 6'd0,  11, 3'd7);
        for (int i = 0; i < 7; i++)
            vecs[7+i] = mk(2'd3, 6'd5, 6'd5, 0, 1, 0, 8, 4'b1000, 0, 6'b00_00_00, 0, 2'd0, 6'd0, 11, 3'(6 - i));
        vecs[14] = mk(2'd3, 6'd10, 6'd5,  0, 1, 0, 0, 4'b0000, 1, 6'b00_00_10, 1, 2'd2, 6'd0,  5,  3'd0);
        vecs[15] = mk(2'd0, 6'd15, 6'd5,  0, 0, 0, 8, 4'b0001, 1, 6'b00_00_10, 16, 2'd3, 6'd10, 27, 3'd4);
        vecs[16] = mk(2'd1, 6'd0,  6'd0,  0, 1, 0, 8, 4'b0010, 0, 6'b00_00_00, 0, 2'd0, 6'd0,  11, 3'd6);

        repeat (2) @(negedge clk);
        chk("rst_motor_en", motor_en, 0);
        chk("rst_coin_req", coin_req, 0);
        chk("rst_coin_type", coin_type, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_change_short", change_short, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_txn_ready", txn_ready, 1);
        for (int i = 0; i < 4; i++) begin
            stock_q_item = 2'(i);
            #1;
            chk($sformatf("rst_stock%0d", i), stock_q, 7);
        end

        for (int v = 0; v < NV; v++) run_vec(vecs[v], v);

        // Reset while waiting on the hopper: outputs clear at once, no done, stock reloaded.
        begin
            int  n = 0;
            bit  saw_done = 0;
            @(negedge clk);
            txn_valid = 1'b1; txn_item = 2'd1; txn_paid = 6'd20; txn_price = 6'd0; txn_cancel = 1'b1;
            @(negedge clk);
            txn_valid = 1'b0; txn_cancel = 1'b0;
            while (!coin_req && n < 10) begin @(negedge clk); n++; end
            chk("rstcw_reached_coin_wait", coin_req, 1);
            chk("rstcw_coin_type", coin_type, 3);
            #2 reset_n = 1'b0;
            #1;
            chk("rstcw_coin_req", coin_req, 0);
            chk("rstcw_coin_type_clr", coin_type, 0);
            chk("rstcw_motor_en", motor_en, 0);
            chk("rstcw_done", done, 0);
            chk("rstcw_status", status, 0);
            chk("rstcw_change_short", change_short, 0);
            @(negedge clk);
            reset_n = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (done) saw_done = 1;
                @(negedge clk);
            end
            chk("rstcw_no_done", saw_done, 0);
            chk("rstcw_ready", txn_ready, 1);
            for (int i = 0; i < 4; i++) begin
                stock_q_item = 2'(i);
                #1;
                chk($sformatf("rstcw_stock%0d", i), stock_q, 7);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
